// File: rtl/alu_pkg.sv
// Shared ALU definitions. The divider's control FSM states are kept here so that
// the ALU control logic can decode the same encoding.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the
// divisor, and keep the difference only when it is non-negative.
module div_step #(
    parameter int unsigned N = 8
) (
    input  logic [N:0]   rem_in,
    input  logic         dividend_bit,
    input  logic [N-1:0] divisor,
    output logic [N:0]   rem_out,
    output logic         q_bit
);

    logic [N+1:0] shifted;

    always_comb begin
        shifted = {rem_in, dividend_bit};
        q_bit   = (shifted >= {2'b00, divisor});
        // rem_in < divisor always holds, so the kept value fits in N+1 bits
        rem_out = (N+1)'(q_bit ? (shifted - {2'b00, divisor}) : shifted);
    end

endmodule

// File: rtl/iterative_divider.sv
// Unsigned restoring divider producing one quotient bit per clock, MSB first.
// A zero divisor bypasses the iteration and reports div_by_zero with the results.
module iterative_divider
    import alu_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int unsigned CntW = $clog2(N);

    div_state_t    state;
    logic [N-1:0]  dividend_sh;  // dividend bits shift out MSB-first, quotient bits shift in
    logic [N-1:0]  divisor_q;
    logic [N:0]    part_rem;
    logic [CntW-1:0] count;

    logic [N:0]    rem_next;
    logic          q_bit;

    div_step #(
        .N(N)
    ) u_div_step (
        .rem_in       (part_rem),
        .dividend_bit (dividend_sh[N-1]),
        .divisor      (divisor_q),
        .rem_out      (rem_next),
        .q_bit        (q_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            dividend_sh <= '0;
            divisor_q   <= '0;
            part_rem    <= '0;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dividend_sh <= a;
                        divisor_q   <= b;
                        part_rem    <= '0;
                        count       <= CntW'(N - 1);
                        div_by_zero <= (b == '0);
                        busy        <= 1'b1;
                        if (b == '0) begin
                            quotient  <= '1;
                            remainder <= a;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    part_rem    <= rem_next;
                    dividend_sh <= {dividend_sh[N-2:0], q_bit};
                    count       <= count - CntW'(1);
                    if (count == '0) begin
                        quotient  <= {dividend_sh[N-2:0], q_bit};
                        remainder <= rem_next[N-1:0];
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/iterative_divider.md
ITERATIVE_DIVIDER -- requirements
Module: iterative_divider

Interface
REQ-001 Parameter N, default 8, operand and result width in bits (N >= 2).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 a  input  N  unsigned dividend, captured when start is accepted.
REQ-006 b  input  N  unsigned divisor, captured when start is accepted.
REQ-007 busy  output  1  high in RUN and DONE states.
REQ-008 done  output  1  one-cycle pulse; results are valid.
REQ-009 quotient  output  N  unsigned quotient.
REQ-010 remainder  output  N  unsigned remainder.
REQ-011 div_by_zero  output  1  high when the captured divisor is zero; held with results.

Function
REQ-012 The divider SHALL be an unsigned restoring divider that resolves one quotient bit per clock, MSB first.
REQ-013 The state machine SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 In IDLE with start=1, the block SHALL capture a and b, clear the partial remainder, load the iteration counter with N-1, and enter RUN; with start=0 it SHALL stay in IDLE.
REQ-015 Each RUN cycle SHALL compute trial = {partial_rem, next dividend bit} - b.
REQ-016 If trial is non-negative, the block SHALL keep it as the partial remainder and shift in quotient bit 1; otherwise it SHALL keep the unsubtracted value and shift in 0.
REQ-017 The partial remainder SHALL be N+1 bits wide so that the subtraction never overflows.
REQ-018 RUN SHALL last exactly N cycles; on the edge where the counter equals 0, the block SHALL enter DONE.
REQ-019 If the start edge sees a start with b=0, the block SHALL skip RUN and go directly to DONE with quotient={N{1}}, remainder=a and div_by_zero=1.
REQ-020 Latency: done SHALL be high in the cycle after the N-th rising edge following acceptance (divide-by-zero: after the 1st edge).
REQ-021 done SHALL be high only in DONE, for exactly one cycle; DONE SHALL return to IDLE unconditionally.
REQ-022 start SHALL be ignored in RUN and DONE; there is no queuing, and the captured operands stay stable.
REQ-023 quotient, remainder and div_by_zero SHALL hold their values from the DONE cycle until the next accepted start.
REQ-024 At acceptance of a new start, div_by_zero SHALL update to reflect the new b.
REQ-025 Changes on a and b outside acceptance SHALL have no effect.
REQ-026 A start that is held high continuously SHALL be re-accepted in the IDLE cycle that follows DONE, giving back-to-back operations every N+2 cycles.

Reset
REQ-027 rst asserted in any state SHALL immediately force IDLE; reset mid-RUN abandons the operation.
REQ-028 While rst is asserted, busy, done, quotient, remainder, div_by_zero, the counter and the partial remainder SHALL all be 0.
REQ-029 The first start SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-030 The state enum typedef (IDLE, RUN, DONE) SHALL reside in the shared package alu_pkg for reuse by the ALU control.
REQ-031 One combinational sub-module, div_step #(N), SHALL implement the trial subtract and restore.
REQ-032 div_step SHALL take partial remainder, dividend bit and divisor, and return the next remainder and the quotient bit.
REQ-033 The counter width SHALL be $clog2(N).
REQ-034 iterative_divider SHALL slot in as the ALU's reserved fourth arithmetic result, gated by busy and done in the processor.

Verification (N=8)
REQ-035 a=200, b=7, start 1 cycle -> done exactly 8 cycles after acceptance; quotient=28, remainder=4, div_by_zero=0.
REQ-036 a=5, b=9 -> quotient=0, remainder=5; a=255, b=1 -> quotient=255, remainder=0; a=255, b=255 -> quotient=1, remainder=0.
REQ-037 a=13, b=0 -> done 1 cycle after acceptance; quotient=0xFF, remainder=13, div_by_zero=1.
REQ-038 Start a=100, b=3; on the 4th RUN cycle pulse start with a=9, b=9 -> ignored; result is quotient=33, remainder=1.
REQ-039 Start a=100, b=3; assert rst asynchronously mid-RUN -> all outputs 0 immediately, IDLE.
REQ-040 After rst deasserts, a=50, b=5 -> quotient=10, remainder=0 after 8 cycles.
REQ-041 Hold start high with random operands -> done pulses every 10 cycles; every result matches a/b and a%b against a reference model.
